// File: rtl/photon_window_counter_if.sv
// photon_window_counter_if: control inputs and result handshake of the photon window counter.
interface photon_window_counter_if #(parameter int CNT_W = 16, parameter int WIN_W = 16);
   logic detA, start, cont, out_ready, out_valid, overflow, busy;
   logic [WIN_W-1:0] window_len;
   logic [CNT_W-1:0] count, lost;
   modport master (output detA, window_len, start, cont, out_ready,
                   input out_valid, count, overflow, lost, busy);
   modport slave (input detA, window_len, start, cont, out_ready,
                  output out_valid, count, overflow, lost, busy);
endinterface

// File: rtl/photon_window_counter.sv
// photon_window_counter: counts detA pulses over a programmable window, holds the result until
// handshaken, and tallies photons that arrive while no window is open.
module photon_window_counter #(parameter int CNT_W = 16, parameter int WIN_W = 16) (
   input logic clk_out,
   input logic reset_n,
   photon_window_counter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
   state_t state, stateNext;
   logic [WIN_W-1:0] timer;
   logic [CNT_W-1:0] acc, accNext, count, lost;
   logic accOvf, ovfNext, overflow, lenOk, handshake, armIdle, arm, lastCycle;
   always_comb begin
      lenOk = bus.window_len != '0;
      handshake = state == HOLD && bus.out_ready;
      armIdle = state == IDLE && bus.start && lenOk;
      arm = armIdle || (handshake && bus.cont && lenOk);
      lastCycle = state == COUNT && timer == WIN_W'(1);
      accNext = (bus.detA && acc != '1) ? acc + CNT_W'(1) : acc;
      ovfNext = accOvf || (bus.detA && acc == '1);
      stateNext = arm ? COUNT : lastCycle ? HOLD : handshake ? IDLE : state;
   end
   always_ff @(posedge clk_out)
      state <= !reset_n ? IDLE : stateNext;
   always_ff @(posedge clk_out) begin
      if (!reset_n) begin
         timer <= '0;
         acc <= '0;
         accOvf <= 1'b0;
         count <= '0;
         overflow <= 1'b0;
         lost <= '0;
      end else begin
         if (arm) begin
            timer <= bus.window_len;
            acc <= '0;
            accOvf <= 1'b0;
         end else if (state == COUNT) begin
            timer <= timer - WIN_W'(1);
            acc <= accNext;
            accOvf <= ovfNext;
         end
         if (lastCycle) begin
            count <= accNext;
            overflow <= ovfNext;
         end
         // arming from IDLE starts a fresh lost tally; a continuous re-arm keeps it
         if (armIdle) lost <= '0;
         else if (state != COUNT && bus.detA && lost != '1) lost <= lost + CNT_W'(1);
      end
   end
   assign bus.count = count;
   assign bus.overflow = overflow;
   assign bus.lost = lost;
   assign bus.out_valid = state == HOLD;
   assign bus.busy = state != IDLE;
endmodule

// File: doc/photon_window_counter.md
PHOTON_WINDOW_COUNTER -- requirements
Module: photon_window_counter

Interface
REQ-001 Parameter CNT_W, default 16: width of the photon count and lost-photon count.
REQ-002 Parameter WIN_W, default 16: width of the window-length input and window timer.
REQ-003 clk_out  input  1  sole clock; the output domain of the edge detector; all logic on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk_out.
REQ-005 detA  input  1  single-cycle detection pulse, already synchronous to clk_out; one high cycle = one photon.
REQ-006 window_len  input  WIN_W  integration window length in clk_out cycles; sampled only when a window is armed.
REQ-007 start  input  1  level-sampled request to arm one window; honoured only in IDLE.
REQ-008 cont  input  1  continuous mode; when high, re-arm immediately after each result handshake.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_valid  output  1  result held and stable.
REQ-011 count  output  CNT_W  photons in the completed window.
REQ-012 overflow  output  1  count saturated during the completed window.
REQ-013 lost  output  CNT_W  photons arriving outside any window since the last arm from IDLE; saturating.
REQ-014 busy  output  1  high in COUNT or HOLD.

Function
REQ-015 Three-state FSM: IDLE, COUNT, HOLD; busy = (state != IDLE).
REQ-016 IDLE -> COUNT on start=1 and window_len!=0; sample window_len into the timer; clear the internal accumulator, overflow flag and lost.
REQ-017 start=1 with window_len=0 in IDLE: ignored; stay in IDLE with no register change.
REQ-018 start in COUNT or HOLD: ignored.
REQ-019 COUNT lasts exactly window_len cycles, starting on the first cycle after the arming edge; the timer decrements once per cycle.
REQ-020 detA=1 on any COUNT cycle, including the first and last, increments the accumulator by 1.
REQ-021 Accumulator saturates at 2^CNT_W-1; an increment attempted at saturation sets the overflow flag for that window.
REQ-022 On the last COUNT cycle (timer==1), go to HOLD next edge; count and overflow load the final accumulator value, including that cycle's detA; out_valid=1 from the first HOLD cycle.
REQ-023 HOLD: count, overflow and out_valid stay stable until out_valid && out_ready at a rising edge.
REQ-024 On handshake with cont=0: go to IDLE; out_valid=0 next cycle; count and overflow keep the last result.
REQ-025 On handshake with cont=1 and window_len!=0: go directly to COUNT; sample window_len, clear the accumulator, do not clear lost; out_valid=0 next cycle.
REQ-026 On handshake with cont=1 and window_len=0: go to IDLE.
REQ-027 detA=1 in IDLE or HOLD increments lost, saturating at 2^CNT_W-1; detA on the handshake cycle counts as lost.
REQ-028 out_ready while out_valid=0 has no effect.
REQ-029 Latency: result visible 1 cycle after the last window cycle; no combinational path from inputs to outputs.

Reset
REQ-030 reset_n=0 at a rising edge: state=IDLE; count=0, overflow=0, lost=0, out_valid=0, busy=0, timer=0, accumulator=0.
REQ-031 Reset mid-COUNT or mid-HOLD discards the window and pending result with no handshake; the first cycle after reset release is IDLE.

Verification
REQ-032 window_len=4, start pulse, detA high on window cycles 1, 2 and 4 -> out_valid one cycle after cycle 4, count=3, overflow=0, busy high for 4 COUNT cycles plus HOLD.
REQ-033 CNT_W=4, window_len=20, detA held high throughout -> count=15, overflow=1.
REQ-034 Result pending and out_ready=0 for 10 cycles with 3 detA pulses -> count stable, lost=3; out_ready=1 -> out_valid=0 next cycle, IDLE.
REQ-035 cont=1, window_len=2, out_ready tied high, detA always high -> back-to-back results count=2, each HOLD lasts 1 cycle, lost increments 1 per HOLD cycle.
REQ-036 start with window_len=0 -> stays IDLE, busy=0, lost unchanged; start during COUNT -> window length unaffected.
REQ-037 reset_n=0 for 1 cycle in the middle of COUNT -> all outputs 0 next cycle; a subsequent start runs a fresh window.
